// File: rtl/mx_rb_pipe_if.sv
// mx_rb_pipe_if -- bundle of the write-back mux/buffer handshake signals.
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high; the producer holds its data stable while valid && !ready, and valid
// does not depend combinationally on ready.
//
// Signals:
//   in_data   NSRC*WIDTH  sources, source k at [k*WIDTH +: WIDTH]
//   S_MX      SEL_W       source select of the input beat
//   in_addr   AW          destination register tag of the input beat
//   in_valid / in_ready   input beat handshake
//   out       WIDTH       selected write-back data (head of buffer)
//   out_addr  AW          tag of the beat on out
//   out_valid / out_ready output beat handshake
//   sel_err               sticky illegal-select flag
//   state_dbg 2           buffer state for observation (0 EMPTY, 1 HALF, 2 FULL)
// Modports: master = beat producer / register-bank side, slave = mx_rb_pipe.
interface mx_rb_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int SEL_W = 2,
    parameter int AW    = 5
);
    logic [NSRC*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      S_MX;
    logic [AW-1:0]         in_addr;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out;
    logic [AW-1:0]         out_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic [1:0]            state_dbg;

    modport master (
        output in_data, S_MX, in_addr, in_valid, out_ready,
        input  in_ready, out, out_addr, out_valid, sel_err, state_dbg
    );

    modport slave (
        input  in_data, S_MX, in_addr, in_valid, out_ready,
        output in_ready, out, out_addr, out_valid, sel_err, state_dbg
    );
endinterface

// File: rtl/mx_rb_pipe.sv
// mx_rb_pipe -- write-back source multiplexer with a 2-entry in-order buffer.
//
// Selects one of NSRC sources (0 PC, 1 DM, 2 ALU) with S_MX, tags it with
// in_addr and queues it toward the register bank. An out-of-range select
// captures zero data and raises the sticky sel_err flag.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; empties the buffer, clears outputs
//   bus    mx_rb_pipe_if.slave (see interface header for signal list)
//
// Build option: define MXRB_BYPASS_EN to forward a beat from input to output
// in the same cycle when the buffer is empty and the consumer is ready.
// Without it the outputs come straight from flops (1-cycle latency).
module mx_rb_pipe #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int SEL_W = 2,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    mx_rb_pipe_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] head_data, head_data_nx;
    logic [AW-1:0]    head_addr, head_addr_nx;
    logic [WIDTH-1:0] tail_data, tail_data_nx;
    logic [AW-1:0]    tail_addr, tail_addr_nx;
    logic             sel_err_q, sel_err_nx;

    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;
    logic             bypass;
    logic             in_ready_i;
    logic             out_valid_i;
    logic             accept;
    logic             complete;

    // Source select; anything at or above NSRC falls through to zero.
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.S_MX == SEL_W'(k)) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
        end
    end

    // Same-cycle forwarding is gated by rst_n so out stays zero during reset.
    always_comb begin
        bypass = 1'b0;
`ifdef MXRB_BYPASS_EN
        bypass = (state == EMPTY) && bus.in_valid && bus.out_ready && rst_n;
`endif
    end

    assign in_ready_i  = (state != FULL);
    assign out_valid_i = (state != EMPTY) || bypass;
    assign accept      = bus.in_valid && in_ready_i;
    assign complete    = out_valid_i && bus.out_ready;

    always_comb begin
        state_nx     = state;
        head_data_nx = head_data;
        head_addr_nx = head_addr;
        tail_data_nx = tail_data;
        tail_addr_nx = tail_addr;
        sel_err_nx   = sel_err_q | (accept && !sel_ok);
        case (state)
            EMPTY: begin
                // A bypassed beat is accepted and completed in one cycle.
                if (accept && !bypass) begin
                    state_nx     = HALF;
                    head_data_nx = sel_data;
                    head_addr_nx = bus.in_addr;
                end
            end
            HALF: begin
                case ({accept, complete})
                    2'b10: begin
                        state_nx     = FULL;
                        tail_data_nx = sel_data;
                        tail_addr_nx = bus.in_addr;
                    end
                    2'b01: state_nx = EMPTY;
                    2'b11: begin
                        head_data_nx = sel_data;
                        head_addr_nx = bus.in_addr;
                    end
                    default: ;
                endcase
            end
            FULL: begin
                if (complete) begin
                    state_nx     = HALF;
                    head_data_nx = tail_data;
                    head_addr_nx = tail_addr;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head_data <= '0;
            head_addr <= '0;
            tail_data <= '0;
            tail_addr <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            head_data <= head_data_nx;
            head_addr <= head_addr_nx;
            tail_data <= tail_data_nx;
            tail_addr <= tail_addr_nx;
            sel_err_q <= sel_err_nx;
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_i;
    assign bus.out       = bypass ? sel_data : head_data;
    assign bus.out_addr  = bypass ? bus.in_addr : head_addr;
    assign bus.sel_err   = sel_err_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_mx_rb_pipe.sv
// tb_mx_rb_pipe -- self-checking bench for mx_rb_pipe (WIDTH=32, NSRC=3).
// Directed table, hand-written corner sequences and a random run, all checked
// against a queue-based model of a 2-deep FIFO with a sticky error flag.
module tb_mx_rb_pipe;
    localparam int WIDTH = 32;
    localparam int NSRC  = 3;
    localparam int SEL_W = 2;
    localparam int AW    = 5;
    localparam int W     = WIDTH + AW;

    logic clk;
    logic rst_n;

    mx_rb_pipe_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .AW(AW)) bus();

    mx_rb_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic         m_sel_err;
    int           checks;
    int           errors;
    int           n_acc;
    int           n_cmp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_sel(input logic [SEL_W-1:0] sel,
                                                  input logic [NSRC*WIDTH-1:0] d);
        if (int'(sel) < NSRC) return d[int'(sel)*WIDTH +: WIDTH];
        return '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_sel_err = 1'b0;
    endtask

    // driver: one beat-cycle, entered and left at a falling edge
    task automatic cycle(input logic v, input logic [SEL_W-1:0] sel, input logic [AW-1:0] addr,
                         input logic [NSRC*WIDTH-1:0] d, input logic rdy);
        logic [WIDTH-1:0] sv;
        logic             byp;
        logic             acc;
        logic             cmp;
        bus.in_valid  = v;
        bus.S_MX      = sel;
        bus.in_addr   = addr;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        sv  = model_sel(sel, d);
        byp = 1'b0;
`ifdef MXRB_BYPASS_EN
        byp = v && rdy && (exp_q.size() == 0);
`endif
        check("in_ready", bus.in_ready, exp_q.size() < 2);
        check("sel_err", bus.sel_err, m_sel_err);
        if (byp) begin
            check("out_valid", bus.out_valid, 1);
            check("out", bus.out, sv);
            check("out_addr", bus.out_addr, addr);
        end else begin
            check("out_valid", bus.out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("out", bus.out, exp_q[0][WIDTH-1:0]);
                check("out_addr", bus.out_addr, exp_q[0][W-1:WIDTH]);
            end
        end
        @(posedge clk);
        acc = v && (exp_q.size() < 2);
        cmp = ((exp_q.size() > 0) || byp) && rdy;
        if (acc && int'(sel) >= NSRC) m_sel_err = 1'b1;
        if (acc) n_acc++;
        if (cmp) n_cmp++;
        if (!byp) begin
            if (cmp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({addr, sv});
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic             v;
        logic [SEL_W-1:0] sel;
        logic [AW-1:0]    addr;
        logic             rdy;
        logic             e_rdy;
        logic             e_vld;
        logic [WIDTH-1:0] e_out;
        logic [AW-1:0]    e_addr;
    } vec_t;

    vec_t                  tbl[5];
    logic [NSRC*WIDTH-1:0] fixed_src;

    initial begin
        checks = 0;
        errors = 0;
        n_acc  = 0;
        n_cmp  = 0;
        m_sel_err = 1'b0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.S_MX      = '0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        fixed_src = {32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000};

        // reset state
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out", bus.out, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_sel_err", bus.sel_err, 0);
        check("rst_state", bus.state_dbg, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table: PC, DM, ALU beats back-to-back with out_ready high
`ifdef MXRB_BYPASS_EN
        tbl[0] = '{1'b1, 2'd0, 5'd1, 1'b1, 1'b1, 1'b1, 32'hFFFF0000, 5'd1};
        tbl[1] = '{1'b1, 2'd1, 5'd2, 1'b1, 1'b1, 1'b1, 32'h0000FFFF, 5'd2};
        tbl[2] = '{1'b1, 2'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd3};
        tbl[3] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0};
        tbl[4] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0};
`else
        tbl[0] = '{1'b1, 2'd0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0};
        tbl[1] = '{1'b1, 2'd1, 5'd2, 1'b1, 1'b1, 1'b1, 32'hFFFF0000, 5'd1};
        tbl[2] = '{1'b1, 2'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'h0000FFFF, 5'd2};
        tbl[3] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd3};
        tbl[4] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = tbl[i].v;
            bus.S_MX      = tbl[i].sel;
            bus.in_addr   = tbl[i].addr;
            bus.in_data   = fixed_src;
            bus.out_ready = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) begin
                check($sformatf("tbl%0d_out", i), bus.out, tbl[i].e_out);
                check($sformatf("tbl%0d_out_addr", i), bus.out_addr, tbl[i].e_addr);
            end
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();

        // backpressure: two beats fill the buffer, third waits
        cycle(1'b1, 2'd0, 5'd10, fixed_src, 1'b0);
        cycle(1'b1, 2'd1, 5'd11, fixed_src, 1'b0);
        bus.in_valid = 1'b1;
        #1;
        check("full_in_ready", bus.in_ready, 0);
        check("full_state", bus.state_dbg, 2);
        cycle(1'b1, 2'd2, 5'd12, fixed_src, 1'b0);
        cycle(1'b1, 2'd2, 5'd12, fixed_src, 1'b1);
        cycle(1'b1, 2'd2, 5'd12, fixed_src, 1'b1);
        cycle(1'b0, 2'd0, 5'd0, fixed_src, 1'b1);
        cycle(1'b0, 2'd0, 5'd0, fixed_src, 1'b1);

        // illegal select: zero data, tag kept, sticky error
        cycle(1'b1, 2'd3, 5'd7, fixed_src, 1'b0);
        #1;
        check("illegal_out", bus.out, 0);
        check("illegal_out_addr", bus.out_addr, 7);
        check("illegal_sel_err", bus.sel_err, 1);
        cycle(1'b1, 2'd0, 5'd8, fixed_src, 1'b1);
        cycle(1'b1, 2'd1, 5'd9, fixed_src, 1'b1);
        cycle(1'b0, 2'd0, 5'd0, fixed_src, 1'b1);
        check("sticky_sel_err", bus.sel_err, 1);

        // asynchronous reset while FULL, observed before the next edge
        cycle(1'b1, 2'd2, 5'd20, fixed_src, 1'b0);
        cycle(1'b1, 2'd1, 5'd21, fixed_src, 1'b0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out", bus.out, 0);
        check("arst_out_addr", bus.out_addr, 0);
        check("arst_sel_err", bus.sel_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_sel_err = 1'b0;
        cycle(1'b1, 2'd2, 5'd22, fixed_src, 1'b0);
        cycle(1'b0, 2'd0, 5'd0, fixed_src, 1'b1);
        cycle(1'b0, 2'd0, 5'd0, fixed_src, 1'b1);

        // random traffic
        do_reset();
        n_acc = 0;
        n_cmp = 0;
        for (int i = 0; i < 2000 && n_acc < 100; i++) begin
            logic [SEL_W-1:0] s;
            s = ($urandom_range(0, 9) == 0) ? SEL_W'(3) : SEL_W'($urandom_range(0, 2));
            cycle(1'($urandom_range(0, 1)), s, AW'($urandom_range(0, 31)),
                  {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        check("rand_accepted", (n_acc >= 100), 1);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            cycle(1'b0, 2'd0, 5'd0, '0, 1'b1);
        check("rand_drained", exp_q.size(), 0);
        check("rand_in_eq_out", n_cmp, n_acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mx_rb_pipe.md
MX_RB_PIPE -- requirements
Module: mx_rb_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each source and of the output.
REQ-002 SHALL have parameter NSRC, default 3: number of selectable sources (index 0 PC, 1 DM, 2 ALU by convention).
REQ-003 SHALL have parameter SEL_W, default 2: select width; SEL_W >= clog2(NSRC), SEL_W >= 1.
REQ-004 SHALL have parameter AW, default 5: destination register address width.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_data, input, NSRC*WIDTH: flattened sources; source k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port S_MX, input, SEL_W: source select for the current input beat.
REQ-009 SHALL have port in_addr, input, AW: destination register tag carried with the beat.
REQ-010 SHALL have port in_valid, input, 1: input beat present.
REQ-011 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-012 SHALL have port out, output, WIDTH: selected write-back data.
REQ-013 SHALL have port out_addr, output, AW: tag of the beat on out.
REQ-014 SHALL have port out_valid, output, 1: out/out_addr hold a valid beat.
REQ-015 SHALL have port out_ready, input, 1: consumer (register bank) accepts the beat.
REQ-016 SHALL have port sel_err, output, 1: sticky illegal-select flag.

Function
REQ-017 SHALL accept a beat on a rising edge where in_valid && in_ready, and complete a beat where out_valid && out_ready.
REQ-018 SHALL, on accept, capture {in_data[S_MX*WIDTH +: WIDTH], in_addr} when S_MX < NSRC.
REQ-019 SHALL, on accept with S_MX >= NSRC, capture data 0, keep in_addr, and set sel_err to 1 on the same edge.
REQ-020 SHALL implement a 2-entry in-order buffer with states EMPTY, HALF, FULL.
REQ-021 SHALL transition EMPTY->HALF on accept; HALF->FULL on accept without complete; HALF->EMPTY on complete without accept; HALF->HALF on simultaneous accept and complete (head replaced by new beat); FULL->HALF on complete (second entry becomes head).
REQ-022 SHALL drive in_ready = 1 in EMPTY and HALF, 0 in FULL, from registered state only (no combinational path from out_ready).
REQ-023 SHALL drive out_valid = 1 in HALF and FULL; out/out_addr SHALL show the head entry and stay stable while out_valid && !out_ready.
REQ-024 SHALL have a latency of 1 cycle from accept to out_valid when empty (without REQ-030), and sustain 1 beat/cycle with out_ready held high.
REQ-025 SHALL ignore in_valid in FULL; in_data/S_MX are don't-care when in_valid = 0.
REQ-026 SHALL hold sel_err at 1 until reset.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state EMPTY, out_valid 0, in_ready 1, out 0, out_addr 0, sel_err 0, regardless of clk.
REQ-028 SHALL discard buffered beats on reset mid-operation; first accept after rst_n rises behaves as from EMPTY.

Configuration
REQ-029 SHALL use macro MXRB_BYPASS_EN to select bypass behaviour.
REQ-030 SHALL, with MXRB_BYPASS_EN defined, in EMPTY with in_valid && out_ready, present the selected input on out/out_addr with out_valid = 1 in the same cycle and remain EMPTY (zero latency); all other cases per REQ-021.
REQ-031 SHALL, without MXRB_BYPASS_EN, have no combinational path from inputs to out/out_valid; latency fixed at 1 cycle.

Verification
REQ-032 SHALL cover: WIDTH=32, NSRC=3, sources FFFF0000/0000FFFF/FFFFFFFF, S_MX=0,1,2 successive beats, out_ready=1 -> out = FFFF0000, 0000FFFF, FFFFFFFF on consecutive cycles, first 1 cycle after first accept.
REQ-033 SHALL cover: out_ready=0, three beats offered -> two accepted, in_ready=0 after second; out_ready=1 -> beats emerge in order, third then accepted.
REQ-034 SHALL cover: S_MX=3 with NSRC=3, in_addr=07 -> out=00000000, out_addr=07, sel_err=1 and remains 1 over later legal beats.
REQ-035 SHALL cover: rst_n=0 in FULL between clock edges -> out_valid=0, in_ready=1, out=0, sel_err=0 before next edge.
REQ-036 SHALL cover: MXRB_BYPASS_EN defined, EMPTY, out_ready=1, S_MX=2, ALU=FFFFFFFF -> out=FFFFFFFF, out_valid=1 same cycle; undefined -> one cycle later.
REQ-037 SHALL cover: 100 random beats with random out_ready -> output sequence equals accepted sequence, no loss or duplication.
